// File: rtl/pc_update_unit.sv
// PC update unit: owns the architectural PC, resolves the next PC from EXU control info
// and alternates between issuing a fetch request and waiting for the resolved result.
module pc_update_unit #(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned          CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_valid,
    input  logic                  ifu_ready,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [1:0]            pc_sel,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] trap_target,
    output logic                  misalign_err,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    localparam logic [0:0] S_ISSUE = 1'b0;
    localparam logic [0:0] S_WAIT  = 1'b1;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_JALR = 2'b10;
    localparam logic [1:0] SEL_TRAP = 2'b11;

    // Trap-vector selections are taken as-is; only computed targets are alignment-checked.
    function automatic logic is_misaligned(input logic [1:0] sel, input logic [ADDR_WIDTH-1:0] target);
        is_misaligned = (sel != SEL_TRAP) && target[1];
    endfunction

    logic [0:0]            state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic                  pc_valid_r;
    logic                  exu_ready_r;
    logic                  misalign_r;
    logic [CNT_WIDTH-1:0]  retire_cnt_r;

    logic [ADDR_WIDTH-1:0] target_s;
    logic [ADDR_WIDTH-1:0] next_pc_s;
    logic                  misalign_s;
    logic                  ifu_hs_s;
    logic                  exu_hs_s;

    assign ifu_hs_s = pc_valid_r && ifu_ready;
    assign exu_hs_s = exu_ready_r && exu_valid;

    // Resolve the control-flow target and redirect misaligned ones to the trap vector.
    always_comb begin
        target_s = pc_r + ADDR_WIDTH'(4);
        case (pc_sel)
            SEL_SEQ:  target_s = pc_r + ADDR_WIDTH'(4);
            SEL_BR:   target_s = pc_r + ADDR_WIDTH'(imm);
            SEL_JALR: target_s = (ADDR_WIDTH'(rs1) + ADDR_WIDTH'(imm)) & ~ADDR_WIDTH'(1);
            SEL_TRAP: target_s = trap_target;
            default:  target_s = trap_target;
        endcase
        misalign_s = is_misaligned(pc_sel, target_s);
        if (misalign_s) begin
            next_pc_s = trap_target;
        end else begin
            next_pc_s = target_s;
        end
    end

    // Handshake FSM with registered request/ready flags, PC, error pulse and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_ISSUE;
            pc_r         <= RESET_PC;
            pc_valid_r   <= 1'b0;
            exu_ready_r  <= 1'b0;
            misalign_r   <= 1'b0;
            retire_cnt_r <= '0;
        end else begin
            misalign_r <= 1'b0;
            case (state_r)
                S_ISSUE: begin
                    if (ifu_hs_s) begin
                        state_r     <= S_WAIT;
                        pc_valid_r  <= 1'b0;
                        exu_ready_r <= 1'b1;
                    end else begin
                        pc_valid_r  <= 1'b1;
                        exu_ready_r <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (exu_hs_s) begin
                        state_r      <= S_ISSUE;
                        pc_r         <= next_pc_s;
                        pc_valid_r   <= 1'b1;
                        exu_ready_r  <= 1'b0;
                        misalign_r   <= misalign_s;
                        retire_cnt_r <= retire_cnt_r + CNT_WIDTH'(1);
                    end else begin
                        pc_valid_r  <= 1'b0;
                        exu_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_ISSUE;
                    pc_valid_r  <= 1'b0;
                    exu_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_r;
    assign pc_valid     = pc_valid_r;
    assign exu_ready    = exu_ready_r;
    assign misalign_err = misalign_r;
    assign retire_cnt   = retire_cnt_r;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed self-checking bench for pc_update_unit (retire counter narrowed to 4 bits to reach wrap).
module tb_pc_update_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        ifu_ready;
    logic        exu_valid;
    logic        exu_ready;
    logic [1:0]  pc_sel;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] trap_target;
    logic        misalign_err;
    logic [3:0]  retire_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    pc_update_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h8000_0000),
        .CNT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .ifu_ready   (ifu_ready),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .pc_sel      (pc_sel),
        .imm         (imm),
        .rs1         (rs1),
        .trap_target (trap_target),
        .misalign_err(misalign_err),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch handshake, one idle WAIT cycle, then an EXU handshake; checks the result and pulse width.
    task automatic xfer(input logic [1:0] sel, input logic [31:0] i_imm, input logic [31:0] i_rs1,
                        input logic [31:0] i_tt, input logic [31:0] exp_pc, input logic exp_mis,
                        input logic [3:0] exp_cnt);
        chk("issue_valid", 32'(pc_valid), 32'd1);
        ifu_ready = 1'b1;
        @(negedge clk);
        ifu_ready = 1'b0;
        chk("wait_valid", 32'(pc_valid), 32'd0);
        chk("wait_ready", 32'(exu_ready), 32'd1);
        @(negedge clk);
        chk("wait_hold_ready", 32'(exu_ready), 32'd1);
        exu_valid   = 1'b1;
        pc_sel      = sel;
        imm         = i_imm;
        rs1         = i_rs1;
        trap_target = i_tt;
        @(negedge clk);
        exu_valid = 1'b0;
        chk("next_pc", pc, exp_pc);
        chk("next_valid", 32'(pc_valid), 32'd1);
        chk("next_ready", 32'(exu_ready), 32'd0);
        chk("misalign", 32'(misalign_err), 32'(exp_mis));
        chk("retire_cnt", 32'(retire_cnt), 32'(exp_cnt));
        @(negedge clk);
        chk("misalign_pulse_end", 32'(misalign_err), 32'd0);
        chk("pc_hold", pc, exp_pc);
    endtask

    initial begin
        rst         = 1'b1;
        ifu_ready   = 1'b0;
        exu_valid   = 1'b0;
        pc_sel      = 2'b00;
        imm         = 32'h0;
        rs1         = 32'h0;
        trap_target = 32'h0;
        @(negedge clk);
        @(negedge clk);
        // T1: reset state and release
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_valid", 32'(pc_valid), 32'd0);
        chk("rst_ready", 32'(exu_ready), 32'd0);
        chk("rst_mis", 32'(misalign_err), 32'd0);
        chk("rst_cnt", 32'(retire_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_valid", 32'(pc_valid), 32'd1);
        chk("rel_pc", pc, 32'h8000_0000);

        // T2: fetch stall with a stray exu_valid that must be ignored
        exu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc", pc, 32'h8000_0000);
            chk("stall_valid", 32'(pc_valid), 32'd1);
            chk("stall_ready", 32'(exu_ready), 32'd0);
        end
        exu_valid = 1'b0;
        chk("stall_cnt", 32'(retire_cnt), 32'd0);
        xfer(2'b00, 32'h0, 32'h0, 32'h0, 32'h8000_0004, 1'b0, 4'd1);

        // T3: branch backward, then JALR landing on a half-word boundary traps
        xfer(2'b01, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h7FFF_FFFC, 1'b0, 4'd2);
        xfer(2'b10, 32'h0000_0002, 32'h8000_1001, 32'h8000_0200, 32'h8000_0200, 1'b1, 4'd3);

        // T4: aligned JALR with bit0 cleared, trap selections (never flagged)
        xfer(2'b10, 32'h0000_0003, 32'h8000_1001, 32'h8000_0200, 32'h8000_1004, 1'b0, 4'd4);
        xfer(2'b11, 32'h0, 32'h0, 32'h8000_0100, 32'h8000_0100, 1'b0, 4'd5);
        xfer(2'b11, 32'h0, 32'h0, 32'h8000_0102, 32'h8000_0102, 1'b0, 4'd6);
        xfer(2'b01, 32'h0000_0002, 32'h0, 32'h0, 32'h8000_0104, 1'b0, 4'd7);

        // T5: PC wrap at the top of the address space, then retire counter wrap
        xfer(2'b11, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 4'd8);
        xfer(2'b00, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 4'd9);
        for (int i = 1; i <= 8; i++) begin
            xfer(2'b00, 32'h0, 32'h0, 32'h0, 32'(4 * i), 1'b0, 4'(9 + i));
        end

        // T6: reset in WAIT with a pending EXU handshake drops it
        ifu_ready = 1'b1;
        @(negedge clk);
        ifu_ready = 1'b0;
        chk("t6_wait_ready", 32'(exu_ready), 32'd1);
        exu_valid   = 1'b1;
        pc_sel      = 2'b11;
        trap_target = 32'h1234_5670;
        rst         = 1'b1;
        @(negedge clk);
        exu_valid = 1'b0;
        chk("t6_pc", pc, 32'h8000_0000);
        chk("t6_cnt", 32'(retire_cnt), 32'd0);
        chk("t6_valid", 32'(pc_valid), 32'd0);
        chk("t6_ready", 32'(exu_ready), 32'd0);
        chk("t6_mis", 32'(misalign_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rel_valid", 32'(pc_valid), 32'd1);
        chk("t6_rel_pc", pc, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
